// File: rtl/pcie_tx_skip_scheduler.sv
// pcie_tx_skip_scheduler
//   Sits between the TX symbol sources (LTSSM training source and data link
//   layer source) and the 8b10b TX lane of a 2-symbol/clk gen1/2 x1 link.
//   Forwards the selected source and, once every SKIP_INTERVAL clocks, owes
//   one SKP ordered set (COM SKP SKP SKP). An owed SKP is sent only after the
//   active source acks the request at a packet boundary; SKPs owed during a
//   long stall accumulate (up to MAX_PENDING) and go out back-to-back.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   link_up                  1 = link-layer source, 0 = training source
//   tx_train_* / tx_ll_*     source symbols, K flags and skip acks
//   tx_skip_req              level request to the active source
//   tx_skip_done             1-clk pulse when the SKP burst has finished
//   tx_data, tx_charisk      registered symbols/K flags to the encoder
//   skip_pending             number of SKP ordered sets still owed
//   skip_overflow            1-clk pulse when a schedule point is lost
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | forward source, nothing owed
// WAIT_ACK | forward source, request raised, waiting for source ack
// SKP0     | emit COM SKP (first half of ordered set)
// SKP1     | emit SKP SKP (second half), retire one owed SKP
module pcie_tx_skip_scheduler #(
  parameter int SKIP_INTERVAL = 600,
  parameter int MAX_PENDING   = 3,
  localparam int PW           = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_up,
  input  logic [15:0]   tx_train_data,
  input  logic [1:0]    tx_train_charisk,
  input  logic          tx_train_skip_ack,
  input  logic [15:0]   tx_ll_data,
  input  logic [1:0]    tx_ll_charisk,
  input  logic          tx_ll_skip_ack,
  output logic          tx_skip_req,
  output logic          tx_skip_done,
  output logic [15:0]   tx_data,
  output logic [1:0]    tx_charisk,
  output logic [PW-1:0] skip_pending,
  output logic          skip_overflow
);

  localparam int CW = (SKIP_INTERVAL > 1) ? $clog2(SKIP_INTERVAL) : 1;

  localparam logic [15:0] SKP_HALF0 = 16'h1CBC;  // K28.5 in [7:0], K28.0 in [15:8]
  localparam logic [15:0] SKP_HALF1 = 16'h1C1C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SKP0     = 2'd2,
    SKP1     = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] interval_cnt;
  logic          sched;
  logic          dec;
  logic          at_max;
  logic [PW-1:0] pending_nxt;
  logic          overflow_nxt;

  logic [15:0]   sel_data;
  logic [1:0]    sel_k;
  logic          sel_ack;

  logic [15:0]   data_nxt;
  logic [1:0]    k_nxt;
  logic          req_nxt;
  logic          done_nxt;

  assign sel_data = link_up ? tx_ll_data     : tx_train_data;
  assign sel_k    = link_up ? tx_ll_charisk  : tx_train_charisk;
  assign sel_ack  = link_up ? tx_ll_skip_ack : tx_train_skip_ack;

  assign sched  = (interval_cnt == CW'(SKIP_INTERVAL - 1));
  assign dec    = (state == SKP1);
  assign at_max = (skip_pending == PW'(MAX_PENDING));

  // A schedule point coinciding with the SKP1 retire cancels out.
  always_comb begin
    pending_nxt  = skip_pending;
    overflow_nxt = sched && at_max;
    if (sched && !dec && !at_max)
      pending_nxt = skip_pending + PW'(1);
    else if (!sched && dec)
      pending_nxt = skip_pending - PW'(1);
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = sel_data;
    k_nxt     = sel_k;
    req_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (skip_pending != '0) begin
          state_nxt = WAIT_ACK;
          req_nxt   = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (sel_ack)
          state_nxt = SKP0;
        else
          req_nxt   = 1'b1;
      end
      SKP0: begin
        data_nxt  = SKP_HALF0;
        k_nxt     = 2'b11;
        state_nxt = SKP1;
      end
      SKP1: begin
        data_nxt = SKP_HALF1;
        k_nxt    = 2'b11;
        // Still owing SKPs: keep bursting without asking the source again.
        if (pending_nxt != '0) begin
          state_nxt = SKP0;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      interval_cnt  <= '0;
      skip_pending  <= '0;
      skip_overflow <= 1'b0;
      tx_data       <= '0;
      tx_charisk    <= '0;
      tx_skip_req   <= 1'b0;
      tx_skip_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      interval_cnt  <= sched ? '0 : interval_cnt + CW'(1);
      skip_pending  <= pending_nxt;
      skip_overflow <= overflow_nxt;
      tx_data       <= data_nxt;
      tx_charisk    <= k_nxt;
      tx_skip_req   <= req_nxt;
      tx_skip_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pcie_tx_skip_scheduler.sv
// Directed testbench for pcie_tx_skip_scheduler with SKIP_INTERVAL=8.
// Edge numbering: edge 1 is the first rising edge with rst low.
module tb_pcie_tx_skip_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up;
  logic [15:0] tx_train_data;
  logic [1:0]  tx_train_charisk;
  logic        tx_train_skip_ack;
  logic [15:0] tx_ll_data;
  logic [1:0]  tx_ll_charisk;
  logic        tx_ll_skip_ack;
  logic        tx_skip_req;
  logic        tx_skip_done;
  logic [15:0] tx_data;
  logic [1:0]  tx_charisk;
  logic [1:0]  skip_pending;
  logic        skip_overflow;

  int total = 0;
  int bad   = 0;

  pcie_tx_skip_scheduler #(.SKIP_INTERVAL(8), .MAX_PENDING(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .link_up           (link_up),
    .tx_train_data     (tx_train_data),
    .tx_train_charisk  (tx_train_charisk),
    .tx_train_skip_ack (tx_train_skip_ack),
    .tx_ll_data        (tx_ll_data),
    .tx_ll_charisk     (tx_ll_charisk),
    .tx_ll_skip_ack    (tx_ll_skip_ack),
    .tx_skip_req       (tx_skip_req),
    .tx_skip_done      (tx_skip_done),
    .tx_data           (tx_data),
    .tx_charisk        (tx_charisk),
    .skip_pending      (skip_pending),
    .skip_overflow     (skip_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    link_up           = 1'b0;
    tx_train_data     = 16'h0000;
    tx_train_charisk  = 2'b00;
    tx_train_skip_ack = 1'b0;
    tx_ll_data        = 16'h0000;
    tx_ll_charisk     = 2'b00;
    tx_ll_skip_ack    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (tx_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", tx_data); end
    total++; if (tx_charisk !== 2'b00) begin bad++; $display("FAIL reset_k got=%b want=00", tx_charisk); end
    total++; if (tx_skip_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", tx_skip_req); end
    total++; if (tx_skip_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tx_skip_done); end
    total++; if (skip_pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", skip_pending); end
    total++; if (skip_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", skip_overflow); end
  endtask

  task automatic test_passthrough();
    do_reset();
    tx_ll_data       = 16'hA55A;
    tx_ll_charisk    = 2'b01;
    tx_train_data    = 16'h3C3C;
    tx_train_charisk = 2'b10;
    link_up          = 1'b1;
    tick();
    total++; if (tx_data !== 16'hA55A) begin bad++; $display("FAIL pass_ll_data got=%h want=a55a", tx_data); end
    total++; if (tx_charisk !== 2'b01) begin bad++; $display("FAIL pass_ll_k got=%b want=01", tx_charisk); end
    link_up = 1'b0;
    tick();
    total++; if (tx_data !== 16'h3C3C) begin bad++; $display("FAIL pass_train_data got=%h want=3c3c", tx_data); end
    total++; if (tx_charisk !== 2'b10) begin bad++; $display("FAIL pass_train_k got=%b want=10", tx_charisk); end
  endtask

  // Ack tied high: req after edge 9, SKP halves after edges 11/12, repeating every 8.
  task automatic test_periodic();
    logic [15:0] ed;
    logic [1:0]  ek;
    logic        ereq, edone;
    int          epend;
    do_reset();
    tx_train_data     = 16'h1234;
    tx_train_charisk  = 2'b01;
    tx_train_skip_ack = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e >= 11 && (e - 11) % 8 == 0)      begin ed = 16'h1CBC; ek = 2'b11; end
      else if (e >= 12 && (e - 12) % 8 == 0) begin ed = 16'h1C1C; ek = 2'b11; end
      else                                   begin ed = 16'h1234; ek = 2'b01; end
      ereq  = (e >= 9) && ((e - 9) % 8 == 0);
      edone = (e >= 12) && ((e - 12) % 8 == 0);
      epend = (e >= 8 && (e - 8) % 8 < 4) ? 1 : 0;
      total++; if (tx_data !== ed) begin bad++; $display("FAIL per_data edge=%0d got=%h want=%h", e, tx_data, ed); end
      total++; if (tx_charisk !== ek) begin bad++; $display("FAIL per_k edge=%0d got=%b want=%b", e, tx_charisk, ek); end
      total++; if (tx_skip_req !== ereq) begin bad++; $display("FAIL per_req edge=%0d got=%b want=%b", e, tx_skip_req, ereq); end
      total++; if (tx_skip_done !== edone) begin bad++; $display("FAIL per_done edge=%0d got=%b want=%b", e, tx_skip_done, edone); end
      total++; if (skip_pending !== 2'(epend)) begin bad++; $display("FAIL per_pending edge=%0d got=%0d want=%0d", e, skip_pending, epend); end
    end
  endtask

  // Stall until pending saturates, then ack through the link-layer source.
  task automatic test_back_to_back();
    int ov = 0;
    int dn = 0;
    logic [15:0] ed;
    do_reset();
    tx_train_data = 16'h4444;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (skip_overflow) ov++;
      if (e == 8)  begin total++; if (skip_pending !== 2'd1) begin bad++; $display("FAIL sat_p1 got=%0d want=1", skip_pending); end end
      if (e == 16) begin total++; if (skip_pending !== 2'd2) begin bad++; $display("FAIL sat_p2 got=%0d want=2", skip_pending); end end
      if (e == 24) begin total++; if (skip_pending !== 2'd3) begin bad++; $display("FAIL sat_p3 got=%0d want=3", skip_pending); end end
      if (e == 20) begin total++; if (tx_skip_req !== 1'b1) begin bad++; $display("FAIL sat_req got=%b want=1", tx_skip_req); end end
    end
    total++; if (skip_pending !== 2'd3) begin bad++; $display("FAIL sat_p32 got=%0d want=3", skip_pending); end
    total++; if (skip_overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", skip_overflow); end
    total++; if (ov != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", ov); end
    link_up        = 1'b1;
    tx_ll_data     = 16'hBEEF;
    tx_ll_charisk  = 2'b00;
    tx_ll_skip_ack = 1'b1;
    for (int e = 33; e <= 40; e++) begin
      tick();
      if (tx_skip_done) dn++;
      case (e)
        34, 36, 38: ed = 16'h1CBC;
        35, 37, 39: ed = 16'h1C1C;
        default:    ed = 16'hBEEF;
      endcase
      total++; if (tx_data !== ed) begin bad++; $display("FAIL b2b_data edge=%0d got=%h want=%h", e, tx_data, ed); end
      if (e == 33) begin total++; if (tx_skip_req !== 1'b0) begin bad++; $display("FAIL b2b_req got=%b want=0", tx_skip_req); end end
      if (e == 33) begin total++; if (skip_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", skip_overflow); end end
      if (e == 39) begin total++; if (skip_pending !== 2'd0) begin bad++; $display("FAIL b2b_pend got=%0d want=0", skip_pending); end end
      if (e == 39) begin total++; if (tx_skip_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", tx_skip_done); end end
    end
    total++; if (dn != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", dn); end
  endtask

  // Ack at edge 14 puts SKP1 on edge 16, which is also a schedule point.
  task automatic test_sched_on_skp1();
    logic [15:0] ed;
    logic        edone;
    do_reset();
    tx_train_data = 16'h5A5A;
    for (int e = 1; e <= 13; e++) tick();
    total++; if (tx_skip_req !== 1'b1) begin bad++; $display("FAIL s1_req got=%b want=1", tx_skip_req); end
    tx_train_skip_ack = 1'b1;
    for (int e = 14; e <= 19; e++) begin
      tick();
      case (e)
        15, 17:  ed = 16'h1CBC;
        16, 18:  ed = 16'h1C1C;
        default: ed = 16'h5A5A;
      endcase
      edone = (e == 18);
      total++; if (tx_data !== ed) begin bad++; $display("FAIL s1_data edge=%0d got=%h want=%h", e, tx_data, ed); end
      total++; if (tx_skip_done !== edone) begin bad++; $display("FAIL s1_done edge=%0d got=%b want=%b", e, tx_skip_done, edone); end
      if (e == 16) begin total++; if (skip_pending !== 2'd1) begin bad++; $display("FAIL s1_pend16 got=%0d want=1", skip_pending); end end
      if (e == 18) begin total++; if (skip_pending !== 2'd0) begin bad++; $display("FAIL s1_pend18 got=%0d want=0", skip_pending); end end
    end
  endtask

  task automatic test_reset_mid_skp();
    do_reset();
    tx_train_data     = 16'h7777;
    tx_train_skip_ack = 1'b1;
    for (int e = 1; e <= 10; e++) tick();
    rst = 1'b1;
    tick();
    total++; if (tx_data !== 16'h0) begin bad++; $display("FAIL rmid_data got=%h want=0000", tx_data); end
    total++; if (tx_charisk !== 2'b00) begin bad++; $display("FAIL rmid_k got=%b want=00", tx_charisk); end
    total++; if (tx_skip_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=0", tx_skip_req); end
    total++; if (tx_skip_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", tx_skip_done); end
    total++; if (skip_pending !== 2'd0) begin bad++; $display("FAIL rmid_pend got=%0d want=0", skip_pending); end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      total++; if (tx_skip_req !== (e == 9)) begin bad++; $display("FAIL rmid_req edge=%0d got=%b want=%b", e, tx_skip_req, (e == 9)); end
      total++; if (tx_skip_done !== 1'b0) begin bad++; $display("FAIL rmid_nodone edge=%0d got=%b want=0", e, tx_skip_done); end
      total++; if (tx_data !== 16'h7777) begin bad++; $display("FAIL rmid_pass edge=%0d got=%h want=7777", e, tx_data); end
    end
  endtask

  task automatic test_ack_idle();
    do_reset();
    tx_train_data = 16'h0F0F;
    for (int e = 1; e <= 6; e++) begin
      tx_train_skip_ack = (e == 2);
      tick();
      total++; if (tx_data !== 16'h0F0F) begin bad++; $display("FAIL idle_data edge=%0d got=%h want=0f0f", e, tx_data); end
      total++; if (tx_skip_req !== 1'b0) begin bad++; $display("FAIL idle_req edge=%0d got=%b want=0", e, tx_skip_req); end
      total++; if (skip_pending !== 2'd0) begin bad++; $display("FAIL idle_pend edge=%0d got=%0d want=0", e, skip_pending); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_periodic();
    test_back_to_back();
    test_sched_on_skp1();
    test_reset_mid_skp();
    test_ack_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
